// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped countdown timer raising irq on expiry.
// Define TIMER_STATUS_REG_EN to expose read-only STATUS at offset 0xC.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_result,
  output logic        hit,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic        en, en_nx;
  logic [1:0]  mode, mode_nx;
  logic        im, im_nx;
  logic [31:0] preset, preset_nx;
  logic [31:0] count, count_nx;
  logic        pending, pending_nx;

  logic [1:0]  off;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        stop;
  logic        reload;
  logic        expire;
  logic        unused_addr;

  assign hit       = addr[31:4] == BASE_ADDR[31:4];
  assign off       = addr[3:2];
  assign wr        = hit & write_enable;
  assign wr_ctrl   = wr & (off == 2'd0);
  assign wr_preset = wr & (off == 2'd1);
  assign stop      = wr_ctrl & ~write_data[0];
  assign reload    = mode == 2'b01;
  assign irq       = pending & im;

  assign unused_addr = ^addr[1:0];

  always_comb begin
    state_nx   = state;
    en_nx      = en;
    mode_nx    = mode;
    im_nx      = im;
    preset_nx  = preset;
    count_nx   = count;
    pending_nx = pending;
    expire     = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) state_nx = LOAD;
      end
      LOAD: begin
        count_nx = preset;
        state_nx = CNT;
      end
      CNT: begin
        if (!en) begin
          state_nx = IDLE;
        end else if (count == '0) begin
          state_nx = INT;
          expire   = 1'b1;
        end else begin
          count_nx = count - 32'd1;
        end
      end
      INT: begin
        if (reload) begin
          state_nx   = LOAD;
          pending_nx = 1'b0;
        end else begin
          state_nx = IDLE;
          en_nx    = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase

    // expiry in the same cycle as a store still latches the event
    if (expire) begin
      pending_nx = 1'b1;
    end else if (!reload && (wr_ctrl || wr_preset)) begin
      pending_nx = 1'b0;
    end

    if (wr_preset) preset_nx = write_data;

    if (wr_ctrl) begin
      en_nx   = write_data[0];
      mode_nx = write_data[2:1];
      im_nx   = write_data[3];
    end

    // clearing EN overrides whatever the FSM planned this edge
    if (stop) begin
      state_nx = IDLE;
      count_nx = count;
      if (state == INT || !reload) pending_nx = 1'b0;
      else pending_nx = pending;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      en      <= 1'b0;
      mode    <= 2'b00;
      im      <= 1'b0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nx;
      en      <= en_nx;
      mode    <= mode_nx;
      im      <= im_nx;
      preset  <= preset_nx;
      count   <= count_nx;
      pending <= pending_nx;
    end
  end

  always_comb begin
    read_result = '0;
    unique case (1'b1)
      hit && off == 2'd0:
        read_result = {28'b0, im, mode, en};
      hit && off == 2'd1:
        read_result = preset;
      hit && off == 2'd2:
        read_result = count;
`ifdef TIMER_STATUS_REG_EN
      hit && off == 2'd3:
        read_result = {28'b0, state, pending, en};
`endif
      default:
        read_result = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: randomized checks of mmio_timer against
// closed-form timing formulas for one-shot and auto-reload runs.
module tb_mmio_timer;

  localparam logic [31:0] BASE   = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_PRE  = BASE + 32'd4;
  localparam logic [31:0] A_CNT  = BASE + 32'd8;
  localparam logic [31:0] A_STAT = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic        write_enable = 1'b0;
  logic [31:0] write_data = '0;
  logic [31:0] read_result;
  logic        hit;
  logic        irq;

  int checks = 0;
  int failures = 0;

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .write_enable(write_enable),
    .write_data(write_data),
    .read_result(read_result),
    .hit(hit),
    .irq(irq)
  );

  always #50 clk = ~clk;

  // k = edges since the edge that stored EN=1
  function automatic logic [31:0] m_count(input int k, input int p,
                                          input bit rel);
    int per;
    int r;
    per = p + 3;
    if (!rel) begin
      if (k >= 2 && k <= p + 2) return 32'(p - (k - 2));
      return 32'd0;
    end
    r = k % per;
    if (r < 2) return 32'd0;
    return 32'(p - (r - 2));
  endfunction

  function automatic bit m_pend(input int k, input int p, input bit rel);
    if (!rel) return k >= p + 3;
    return (k >= p + 3) && (k % (p + 3) == 0);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    write_data = d;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = read_result;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] alist [5];
    alist = '{A_CTRL, A_PRE, A_CNT, A_STAT, 32'h1234_5678};
    repeat (2) tick();
    rd(A_CTRL, v);
    checks++;
    if (v !== 32'd0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold ctrl=%0h irq=%b exp 0/0", v, irq);
    end
    rst = 1'b1;
    tick();
    rd(A_CNT, v);
    checks++;
    if (v !== 32'd0) begin
      failures++;
      $display("FAIL reset_count got=%0h exp=0", v);
    end
    wr(A_PRE, 32'd5);
    wr(A_CTRL, 32'h9);
    repeat (4) tick();
    rd(A_CNT, v);
    checks++;
    if (v !== 32'd3) begin
      failures++;
      $display("FAIL reset_precount got=%0h exp=3", v);
    end
    rst = 1'b0;
    foreach (alist[i]) begin
      rd(alist[i], v);
      checks++;
      if (v !== 32'd0) begin
        failures++;
        $display("FAIL reset_async a=%0h got=%0h exp=0", alist[i], v);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (irq !== 1'b0) begin
        failures++;
        $display("FAIL reset_irq cyc=%0d got=%b exp=0", i, irq);
      end
    end
    rst = 1'b1;
    tick();
    rd(A_CTRL, v);
    checks++;
    if (v !== 32'd0) begin
      failures++;
      $display("FAIL reset_release_ctrl got=%0h exp=0", v);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      rd(A_CNT, v);
      checks++;
      if (irq !== 1'b0 || v !== 32'd0) begin
        failures++;
        $display("FAIL reset_abort cyc=%0d irq=%b cnt=%0h exp 0/0",
                 i, irq, v);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    logic [31:0] e;
    int p;
    bit im;
    logic [1:0] md;
    logic [1:0] mds [3];
    mds = '{2'b00, 2'b10, 2'b11};
    for (int it = 0; it < 6; it++) begin
      p  = (it == 0) ? 3 : int'($urandom_range(0, 9));
      im = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      md = (it == 0) ? 2'b00 : mds[$urandom_range(0, 2)];
      wr(A_CTRL, 32'd0);
      wr(A_PRE, 32'(p));
      wr(A_CTRL, {28'b0, im, md, 1'b1});
      for (int k = 1; k <= p + 6; k++) begin
        tick();
        rd(A_CNT, v);
        if (k >= 2) begin
          e = m_count(k, p, 1'b0);
          checks++;
          if (v !== e) begin
            failures++;
            $display("FAIL oneshot_count p=%0d k=%0d got=%0h exp=%0h",
                     p, k, v, e);
          end
        end
        checks++;
        if (irq !== (im & m_pend(k, p, 1'b0))) begin
          failures++;
          $display("FAIL oneshot_irq p=%0d k=%0d got=%b exp=%b",
                   p, k, irq, im & m_pend(k, p, 1'b0));
        end
      end
      rd(A_CTRL, v);
      e = {28'b0, im, md, 1'b0};
      checks++;
      if (v !== e) begin
        failures++;
        $display("FAIL oneshot_ctrl p=%0d got=%0h exp=%0h", p, v, e);
      end
      wr(A_PRE, 32'd7);
      checks++;
      if (irq !== 1'b0) begin
        failures++;
        $display("FAIL oneshot_clear p=%0d got=%b exp=0", p, irq);
      end
    end
  endtask

  task automatic test_preset_midcount();
    logic [31:0] v;
    wr(A_CTRL, 32'd0);
    wr(A_PRE, 32'd6);
    wr(A_CTRL, 32'h9);
    repeat (2) tick();
    wr(A_PRE, 32'd1);
    for (int k = 3; k <= 10; k++) begin
      if (k > 3) tick();
      rd(A_CNT, v);
      checks++;
      if (v !== m_count(k, 6, 1'b0) || irq !== m_pend(k, 6, 1'b0)) begin
        failures++;
        $display("FAIL midpre k=%0d cnt=%0h irq=%b exp=%0h/%b", k, v,
                 irq, m_count(k, 6, 1'b0), m_pend(k, 6, 1'b0));
      end
    end
    wr(A_CTRL, 32'h9);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (irq !== m_pend(k, 1, 1'b0)) begin
        failures++;
        $display("FAIL midpre_next k=%0d got=%b exp=%b", k, irq,
                 m_pend(k, 1, 1'b0));
      end
    end
  endtask

  task automatic test_ctrl_wins();
    logic [31:0] v;
    wr(A_CTRL, 32'd0);
    wr(A_PRE, 32'd0);
    wr(A_CTRL, 32'h9);
    repeat (3) tick();
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL wins_int got=%b exp=1", irq);
    end
    wr(A_CTRL, 32'h9);
    rd(A_CTRL, v);
    checks++;
    if (v !== 32'h9 || irq !== 1'b0) begin
      failures++;
      $display("FAIL wins_ctrl ctrl=%0h irq=%b exp 9/0", v, irq);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (irq !== m_pend(k, 0, 1'b0)) begin
        failures++;
        $display("FAIL wins_restart k=%0d got=%b exp=%b", k, irq,
                 m_pend(k, 0, 1'b0));
      end
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    logic [31:0] frz;
    int p;
    int kstop;
    for (int it = 0; it < 3; it++) begin
      p = (it == 0) ? 2 : int'($urandom_range(0, 6));
      kstop = (it == 0) ? 4 * (p + 3)
                        : int'($urandom_range(p + 3, 3 * (p + 3)));
      wr(A_CTRL, 32'd0);
      wr(A_PRE, 32'(p));
      wr(A_CTRL, 32'hB);
      for (int k = 1; k <= kstop; k++) begin
        tick();
        rd(A_CNT, v);
        checks++;
        if (irq !== m_pend(k, p, 1'b1) || v !== m_count(k, p, 1'b1)) begin
          failures++;
          $display("FAIL reload p=%0d k=%0d irq=%b cnt=%0h exp=%b/%0h",
                   p, k, irq, v, m_pend(k, p, 1'b1), m_count(k, p, 1'b1));
        end
        rd(A_CTRL, v);
        checks++;
        if (v !== 32'hB) begin
          failures++;
          $display("FAIL reload_ctrl p=%0d k=%0d got=%0h exp=b", p, k, v);
        end
      end
      frz = m_count(kstop, p, 1'b1);
      wr(A_CTRL, 32'd0);
      for (int i = 0; i < 4; i++) begin
        tick();
        rd(A_CNT, v);
        checks++;
        if (v !== frz || irq !== 1'b0) begin
          failures++;
          $display("FAIL reload_stop p=%0d cnt=%0h irq=%b exp=%0h/0",
                   p, v, irq, frz);
        end
      end
    end
  endtask

  task automatic test_disable();
    logic [31:0] v;
    wr(A_CTRL, 32'd0);
    wr(A_PRE, 32'd10);
    wr(A_CTRL, 32'h1);
    repeat (4) tick();
    wr(A_CTRL, 32'd0);
    for (int i = 0; i < 12; i++) begin
      rd(A_CNT, v);
      checks++;
      if (v !== 32'd8 || irq !== 1'b0) begin
        failures++;
        $display("FAIL disable cyc=%0d cnt=%0h irq=%b exp 8/0", i, v, irq);
      end
      tick();
    end
    rd(A_STAT, v);
    checks++;
    if (v !== 32'd0) begin
      failures++;
      $display("FAIL disable_status got=%0h exp=0", v);
    end
  endtask

  task automatic test_mask();
    logic [31:0] v;
    logic [31:0] e;
    int p;
    p = int'($urandom_range(0, 8));
    wr(A_CTRL, 32'd0);
    wr(A_PRE, 32'(p));
    wr(A_CTRL, 32'h1);
    for (int k = 1; k <= p + 6; k++) begin
      tick();
      checks++;
      if (irq !== 1'b0) begin
        failures++;
        $display("FAIL mask_irq p=%0d k=%0d got=%b exp=0", p, k, irq);
      end
    end
`ifdef TIMER_STATUS_REG_EN
    e = 32'h2;
`else
    e = 32'h0;
`endif
    rd(A_STAT, v);
    checks++;
    if (v !== e) begin
      failures++;
      $display("FAIL mask_status got=%0h exp=%0h", v, e);
    end
    wr(A_CTRL, 32'h8);
    rd(A_CTRL, v);
    checks++;
    if (irq !== 1'b0 || v !== 32'h8) begin
      failures++;
      $display("FAIL mask_clear irq=%b ctrl=%0h exp 0/8", irq, v);
    end
  endtask

  task automatic test_status();
    logic [31:0] v;
    logic [31:0] exp_s [4];
`ifdef TIMER_STATUS_REG_EN
    exp_s = '{32'h1, 32'h5, 32'h9, 32'hF};
`else
    exp_s = '{32'h0, 32'h0, 32'h0, 32'h0};
`endif
    wr(A_CTRL, 32'd0);
    wr(A_PRE, 32'd4);
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      rd(A_STAT, v);
      checks++;
      if (v !== exp_s[i]) begin
        failures++;
        $display("FAIL status k=%0d got=%0h exp=%0h", i, v, exp_s[i]);
      end
    end
    wr(A_STAT, 32'hFFFF_FFFF);
    wr(A_CNT, 32'h55);
    rd(A_CNT, v);
    checks++;
    if (v !== m_count(4, 4, 1'b0)) begin
      failures++;
      $display("FAIL status_ro cnt=%0h exp=%0h", v, m_count(4, 4, 1'b0));
    end
    repeat (3) tick();
    rd(A_STAT, v);
    checks++;
    if (v !== exp_s[3]) begin
      failures++;
      $display("FAIL status_int got=%0h exp=%0h", v, exp_s[3]);
    end
  endtask

  task automatic test_decode();
    logic [31:0] v;
    wr(A_CTRL, 32'd0);
    wr(A_PRE, 32'hA5A5_0001);
    rd(BASE + 32'h10, v);
    checks++;
    if (hit !== 1'b0 || v !== 32'd0) begin
      failures++;
      $display("FAIL decode_miss hit=%b rd=%0h exp 0/0", hit, v);
    end
    wr(BASE + 32'h10, 32'hFFFF_FFFF);
    wr(BASE - 32'h4, 32'hFFFF_FFFF);
    wr(BASE + 32'h14, 32'hFFFF_FFFF);
    rd(BASE + 32'h7, v);
    checks++;
    if (hit !== 1'b1 || v !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL decode_pre hit=%b rd=%0h exp 1/a5a50001", hit, v);
    end
    rd(A_CTRL, v);
    checks++;
    if (v !== 32'd0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL decode_ctrl ctrl=%0h irq=%b exp 0/0", v, irq);
    end
    wr(A_CTRL + 32'h3, 32'hFFFF_FFF4);
    rd(A_CTRL, v);
    checks++;
    if (v !== 32'h4) begin
      failures++;
      $display("FAIL decode_rsvd got=%0h exp=4", v);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_preset_midcount();
    test_ctrl_wins();
    test_autoreload();
    test_disable();
    test_mask();
    test_status();
    test_decode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
